// File: rtl/assoc_wb_cache_if.sv
// Bus bundle between the CPU/memory environment (master) and the cache (slave).
// Carries the CPU request port, the line-wide memory port and the perf counters.
interface assoc_wb_cache_if #(
  parameter int WORD_SIZE         = 16,
  parameter int ADDR_SIZE         = 16,
  parameter int NUM_WORD_PER_LINE = 4
);
  localparam int LINE_SIZE = WORD_SIZE * NUM_WORD_PER_LINE;

  logic                 readCache;
  logic                 writeCache;
  logic [ADDR_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 stall;
  logic [ADDR_SIZE-1:0] address_to_memory;
  logic                 readM;
  logic                 writeM;
  logic [LINE_SIZE-1:0] mem_wdata;
  logic [LINE_SIZE-1:0] mem_rdata;
  logic                 mem_ready;
  logic [15:0]          hit_count;
  logic [15:0]          miss_count;

  modport master (
    output readCache, writeCache, address, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall, address_to_memory, readM, writeM, mem_wdata,
           hit_count, miss_count
  );

  modport slave (
    input  readCache, writeCache, address, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, stall, address_to_memory, readM, writeM, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with per-set LRU ages,
// ready-handshaked line memory port and saturating hit/miss counters.
//
// state | meaning
// IDLE  | serve hits combinationally; on a miss latch victim and leave
// WB    | writeM high, dirty victim line offered until mem_ready
// FILL  | readM high, requested line installed into victim way on mem_ready
module assoc_wb_cache #(
  parameter int WORD_SIZE         = 16,
  parameter int ADDR_SIZE         = 16,
  parameter int NUM_SET           = 4,
  parameter int NUM_WAY           = 2,
  parameter int NUM_WORD_PER_LINE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  assoc_wb_cache_if.slave  bus
);
  localparam int LINE_SIZE  = WORD_SIZE * NUM_WORD_PER_LINE;
  localparam int BO_SIZE    = $clog2(NUM_WORD_PER_LINE);
  localparam int INDEX_SIZE = $clog2(NUM_SET);
  localparam int TAG_SIZE   = ADDR_SIZE - INDEX_SIZE - BO_SIZE;
  localparam int WAY_W      = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

  state_e                state_q;
  logic                  valid_q [NUM_SET][NUM_WAY];
  logic                  dirty_q [NUM_SET][NUM_WAY];
  logic [TAG_SIZE-1:0]   tag_q   [NUM_SET][NUM_WAY];
  logic [LINE_SIZE-1:0]  data_q  [NUM_SET][NUM_WAY];
  logic [WAY_W-1:0]      age_q   [NUM_SET][NUM_WAY];
  logic [WAY_W-1:0]      age_d   [NUM_WAY];

  logic [TAG_SIZE-1:0]   miss_tag_q;
  logic [INDEX_SIZE-1:0] miss_idx_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  suppress_q;
  logic                  readM_q, writeM_q;
  logic [ADDR_SIZE-1:0]  addr_mem_q;
  logic [LINE_SIZE-1:0]  mem_wdata_q;
  logic [15:0]           hit_count_q, miss_count_q;

  logic [TAG_SIZE-1:0]   tag;
  logic [INDEX_SIZE-1:0] idx;
  logic [BO_SIZE-1:0]    bo;
  logic                  request, hit;
  logic [WAY_W-1:0]      hit_way, victim;
  logic [LINE_SIZE-1:0]  hit_line;

  assign {tag, idx, bo} = bus.address;
  assign request        = bus.readCache | bus.writeCache;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way by default; the lowest-index invalid way takes priority.
  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAY; w++)
      if (age_q[idx][w] == WAY_W'(NUM_WAY - 1)) victim = WAY_W'(w);
    for (int w = NUM_WAY - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = WAY_W'(w);
  end

  always_comb begin
    for (int v = 0; v < NUM_WAY; v++) begin
      age_d[v] = age_q[idx][v];
      if (age_q[idx][v] < age_q[idx][hit_way]) age_d[v] = age_q[idx][v] + 1'b1;
    end
    age_d[hit_way] = '0;
  end

  assign hit_line              = data_q[idx][hit_way];
  assign bus.stall             = (state_q != IDLE) | (request & ~hit);
  assign bus.cpu_rdata         = (state_q == IDLE && bus.readCache && hit)
                                 ? hit_line[int'(bo)*WORD_SIZE +: WORD_SIZE] : '0;
  assign bus.readM             = readM_q;
  assign bus.writeM            = writeM_q;
  assign bus.address_to_memory = addr_mem_q;
  assign bus.mem_wdata         = mem_wdata_q;
  assign bus.hit_count         = hit_count_q;
  assign bus.miss_count        = miss_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      victim_q     <= '0;
      suppress_q   <= 1'b0;
      readM_q      <= 1'b0;
      writeM_q     <= 1'b0;
      addr_mem_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < NUM_SET; s++) begin
        for (int w = 0; w < NUM_WAY; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (request && hit) begin
            age_q[idx] <= age_d;
            if (bus.writeCache) begin
              data_q[idx][hit_way][int'(bo)*WORD_SIZE +: WORD_SIZE] <= bus.cpu_wdata;
              dirty_q[idx][hit_way] <= 1'b1;
            end
            // The hit that completes a miss was already counted as a miss.
            if (suppress_q)
              suppress_q <= 1'b0;
            else if (hit_count_q != 16'hFFFF)
              hit_count_q <= hit_count_q + 16'd1;
          end else if (request) begin
            if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            suppress_q <= 1'b1;
            miss_tag_q <= tag;
            miss_idx_q <= idx;
            victim_q   <= victim;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              state_q     <= WB;
              writeM_q    <= 1'b1;
              addr_mem_q  <= {tag_q[idx][victim], idx, {BO_SIZE{1'b0}}};
              mem_wdata_q <= data_q[idx][victim];
            end else begin
              state_q    <= FILL;
              readM_q    <= 1'b1;
              addr_mem_q <= {tag, idx, {BO_SIZE{1'b0}}};
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            dirty_q[miss_idx_q][victim_q] <= 1'b0;
            writeM_q    <= 1'b0;
            mem_wdata_q <= '0;
            readM_q     <= 1'b1;
            addr_mem_q  <= {miss_tag_q, miss_idx_q, {BO_SIZE{1'b0}}};
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            data_q[miss_idx_q][victim_q]  <= bus.mem_rdata;
            tag_q[miss_idx_q][victim_q]   <= miss_tag_q;
            valid_q[miss_idx_q][victim_q] <= 1'b1;
            dirty_q[miss_idx_q][victim_q] <= 1'b0;
            readM_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between the CPU datapath and line-wide main memory.
- Generalises the direct-mapped single-level cache to configurable sets, ways and line length.
- Adds valid bits, per-set LRU replacement and a ready-handshaked memory interface in place of fixed-latency timing.
- Adds hit/miss performance counters.

Parameters:
- WORD_SIZE, 16, CPU word width in bits.
- ADDR_SIZE, 16, word-address width.
- NUM_SET, 4, number of sets; power of 2, at least 2.
- NUM_WAY, 2, ways per set; power of 2, at least 1.
- NUM_WORD_PER_LINE, 4, words per line; power of 2, at least 2.
- Derived widths:
  - LINE_SIZE = WORD_SIZE*NUM_WORD_PER_LINE.
  - BO_SIZE = log2(NUM_WORD_PER_LINE).
  - INDEX_SIZE = log2(NUM_SET).
  - TAG_SIZE = ADDR_SIZE-INDEX_SIZE-BO_SIZE.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- readCache  in  1  CPU read request; held until stall is low.
- writeCache  in  1  CPU write request; held until stall is low.
- address  in  ADDR_SIZE  word address, split as {tag, index, bo}.
- cpu_wdata  in  WORD_SIZE  write data; held with writeCache.
- cpu_rdata  out  WORD_SIZE  read data; valid when readCache=1 and stall=0.
- stall  out  1  CPU must hold its request while this is high.
- address_to_memory  out  ADDR_SIZE  line-aligned memory address (bo bits = 0).
- readM  out  1  line fill request.
- writeM  out  1  line write-back request.
- mem_wdata  out  LINE_SIZE  write-back line; word 0 in the LSBs.
- mem_rdata  in  LINE_SIZE  fill line; word 0 in the LSBs.
- mem_ready  in  1  memory completes the current readM/writeM transfer this cycle.
- hit_count  out  16  saturating count of hit requests.
- miss_count  out  16  saturating count of miss requests.

Behaviour:
- Reset (reset_n low at posedge):
  - All valid and dirty bits cleared.
  - LRU age of way w set to w in every set.
  - FSM to IDLE; counters cleared.
  - readM=0, writeM=0, address_to_memory=0, mem_wdata=0.
  - stall and cpu_rdata follow their combinational rules.
- Reset mid-transfer: the transfer is abandoned, readM/writeM are low from the next cycle, and no partial line is installed.
- Hit: valid way whose tag matches in set index. Multiple matches are impossible by construction.
- Request: readCache|writeCache. If both are high, the request is treated as a write.
- stall = (state!=IDLE) | (request & ~hit). This is combinational; a hit costs 0 stall cycles.
- Read hit:
  - cpu_rdata = line word bo, combinationally in the same cycle.
  - On the posedge, the LRU entry is updated.
- Write hit: on the posedge, word bo = cpu_wdata, dirty=1, LRU updated.
- cpu_rdata = 0 whenever no read hit is being served.
- Victim selection, on a miss in IDLE:
  - Lowest-index invalid way; otherwise the way with age NUM_WAY-1.
  - The victim is latched at the IDLE exit edge together with tag and index.
- LRU update on access to way w of age a: every way in the set with age < a increments, and way w's age becomes 0. Ages stay a permutation of 0..NUM_WAY-1.
- FSM states:
  - IDLE:
    - On a miss, go to WB if the victim is valid and dirty, else go to FILL.
    - The miss is counted on this edge.
  - WB:
    - writeM=1.
    - address_to_memory = {victim tag, index, 0}.
    - mem_wdata = victim line.
    - Held until mem_ready; then dirty is cleared and the FSM goes to FILL.
  - FILL:
    - readM=1.
    - address_to_memory = {tag, index, 0}.
    - On mem_ready, mem_rdata is installed into the victim way with tag, valid=1, dirty=0, and the FSM goes to IDLE.
- After FILL the request hits in IDLE and is served normally. That completing hit is not counted in hit_count; a one-bit flag set on the miss edge suppresses it.
- readM and writeM are never high together.
- mem_ready outside WB/FILL is ignored.
- Miss latency = WB wait + FILL wait + 1 cycles (clean victim with mem_ready at 1 cycle: stall high for 2 cycles).
- Counters saturate at 16'hFFFF.
- The address and data inputs must be stable while stall is high; the cache re-samples them in IDLE.

Test Plan (defaults: tag=address[15:4], index=address[3:2], bo=address[1:0]):
- Cold read of 0x0011 with mem_rdata=64'h4444_3333_2222_1111 and mem_ready after 3 cycles:
  - readM high with address_to_memory=0x0010.
  - Then cpu_rdata=16'h2222 with stall low.
  - miss_count=1, hit_count=0.
- Read of 0x0013 immediately afterwards:
  - stall stays low, cpu_rdata=16'h4444.
  - No readM; hit_count=1.
- Write 16'hBEEF to 0x0012 (hit), then read-miss 0x0020 and 0x0030, all index 0:
  - 0x0020 fills the free way.
  - 0x0030 evicts LRU line 0x0010 via WB with mem_wdata=64'h4444_BEEF_2222_1111 at address 0x0010, then FILL at 0x0030.
- LRU check with 2 ways: fill 0x0000 and 0x0010, read 0x0000, then miss on 0x0020:
  - Victim is the 0x0010 way.
  - Its clean victim means no writeM; FILL only.
- Simultaneous readCache=1 and writeCache=1 at 0x0010 holding cpu_wdata=16'h00AA:
  - Treated as a write; a subsequent read returns 16'h00AA.
- reset_n low during FILL before mem_ready:
  - readM=0 next cycle, state IDLE, and a re-read of the same address misses again.
